// File: rtl/hack_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package hack_mem_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 16;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/hack_mem_arbiter_mux16.sv
// Two-input word multiplexer used for the shared memory address and write data.
module mux16 #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Fetch/data arbiter for a single-port memory: IDLE -> ACCESS -> RESP per access.
// Define HACK_ARB_FIXED_PRIO_EN to give the data requester fixed tie priority.
module hack_mem_arbiter
  import hack_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic        mem_en_q, mem_en_d;
  logic        busy_q, busy_d;
  logic        win;
  logic [DATA_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic        we_sel;
`ifndef HACK_ARB_FIXED_PRIO_EN
  logic        last_q, last_d;
`endif

  always_comb begin
`ifdef HACK_ARB_FIXED_PRIO_EN
    win = req1 ? DATA : FETCH;
`else
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = DATA;
    end else begin
      win = FETCH;
    end
`endif
  end

  // Outputs are computed from the next state so they appear registered in the state they describe.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifndef HACK_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          sel_d   = win;
`ifndef HACK_ARB_FIXED_PRIO_EN
          last_d  = win;
`endif
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gnt_d    = (state_d != IDLE) ? onehot(sel_d) : 2'b00;
    ack_d    = (state_d == RESP) ? onehot(sel_d) : 2'b00;
    mem_en_d = (state_d == ACCESS);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= FETCH;
`ifndef HACK_ARB_FIXED_PRIO_EN
      last_q   <= DATA;
`endif
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
`ifndef HACK_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      mem_en_q <= mem_en_d;
      busy_q   <= busy_d;
    end
  end

  mux16 #(.W(DATA_W)) u_addr_mux (
    .sel (sel_q),
    .in0 (addr0),
    .in1 (addr1),
    .out (addr_sel)
  );

  mux16 #(.W(DATA_W)) u_wdata_mux (
    .sel (sel_q),
    .in0 (wdata0),
    .in1 (wdata1),
    .out (wdata_sel)
  );

  // Requester fields are used live, gated so the memory port reads zero outside ACCESS.
  assign we_sel    = sel_q ? we1 : we0;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_en_q & we_sel;
  assign mem_addr  = mem_en_q ? addr_sel : '0;
  assign mem_wdata = mem_en_q ? wdata_sel : '0;
  assign rdata     = (ack_q != 2'b00) ? mem_rdata : '0;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Randomized self-checking bench for hack_mem_arbiter against a transaction-level model.
// Build with HACK_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_hack_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic [1:0]  gnt, ack;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_rdata = 16'h0000;

  logic [15:0] mem    [256];
  logic [15:0] shadow [256];
  logic        mem_inited = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          phase;
  int          win_m;
`ifndef HACK_ARB_FIXED_PRIO_EN
  int          last_m;
`endif
  logic [15:0] exp_rdata;
  logic        pending [2];
  logic [1:0]  gnt_log [$];
  int          ack_cnt [2];

  hack_mem_arbiter #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req_v[0]),
    .req1      (req_v[1]),
    .addr0     (addr_v[0]),
    .addr1     (addr_v[1]),
    .wdata0    (wdata_v[0]),
    .wdata1    (wdata_v[1]),
    .we0       (we_v[0]),
    .we1       (we_v[1]),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seedVal(input int i);
    if (i == 'h34) return 16'hAAAA;
    return 16'(i * 16'h0101) ^ 16'h3C5A;
  endfunction

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Memory with one-cycle read latency, returning the old contents on a write.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= seedVal(i);
      mem_inited <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr[7:0]];
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle();
    if (mem_en === 1'b1) gnt_log.push_back(gnt);
    for (int i = 0; i < 2; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
    case (phase)
      0: begin
        checkOutput("gnt_idle", gnt, 0);
        checkOutput("ack_idle", ack, 0);
        checkOutput("rdata_idle", rdata, 0);
        checkOutput("mem_en_idle", mem_en, 0);
        checkOutput("mem_we_idle", mem_we, 0);
        checkOutput("busy_idle", busy, 0);
      end
      1: begin
        checkOutput("gnt_access", gnt, oh(win_m));
        checkOutput("ack_access", ack, 0);
        checkOutput("rdata_access", rdata, 0);
        checkOutput("mem_en_access", mem_en, 1);
        checkOutput("mem_we_access", mem_we, we_v[win_m]);
        checkOutput("mem_addr_access", mem_addr, addr_v[win_m]);
        checkOutput("mem_wdata_access", mem_wdata, wdata_v[win_m]);
        checkOutput("busy_access", busy, 1);
      end
      default: begin
        checkOutput("gnt_resp", gnt, oh(win_m));
        checkOutput("ack_resp", ack, oh(win_m));
        checkOutput("rdata_resp", rdata, exp_rdata);
        checkOutput("mem_en_resp", mem_en, 0);
        checkOutput("mem_we_resp", mem_we, 0);
        checkOutput("busy_resp", busy, 1);
      end
    endcase
  endtask

  // Transaction view: an accepted request takes one memory cycle, then one response cycle.
  task automatic advanceModel();
    case (phase)
      0: begin
        if (req_v[0] || req_v[1]) begin
`ifdef HACK_ARB_FIXED_PRIO_EN
          win_m = req_v[1] ? 1 : 0;
`else
          if (req_v[0] && req_v[1]) win_m = 1 - last_m;
          else win_m = req_v[1] ? 1 : 0;
          last_m = win_m;
`endif
          phase = 1;
        end
      end
      1: begin
        exp_rdata = shadow[addr_v[win_m][7:0]];
        if (we_v[win_m]) shadow[addr_v[win_m][7:0]] = wdata_v[win_m];
        phase = 2;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic applyStimulus(input logic r0, input logic r1);
    req_v[0] = r0;
    req_v[1] = r1;
  endtask

  task automatic driveCycle(input logic r0, input logic r1);
    @(negedge clk);
    checkCycle();
    applyStimulus(r0, r1);
    advanceModel();
  endtask

  task automatic resetModel();
    phase = 0;
    win_m = 0;
`ifndef HACK_ARB_FIXED_PRIO_EN
    last_m = 1;
`endif
    exp_rdata = 16'h0000;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, gnt, 0);
    checkOutput({tag, "_ack"}, ack, 0);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_mem_en"}, mem_en, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = seedVal(i);
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0;
      we_v[i] = 1'b0;
      addr_v[i] = 16'h0000;
      wdata_v[i] = 16'h0000;
      ack_cnt[i] = 0;
    end
    resetModel();
    rst_n = 1'b0;
    #3;
    checkAllZero("reset");
    driveCycle(1'b0, 1'b0);
    rst_n = 1'b1;

    // Single read from the fetch port, dropping req0 during ACCESS.
    addr_v[0] = 16'h1234;
    we_v[0] = 1'b0;
    driveCycle(1'b1, 1'b0);
    driveCycle(1'b0, 1'b0);
    checkOutput("read_mem_en", mem_en, 1);
    checkOutput("read_mem_addr", mem_addr, 16'h1234);
    driveCycle(1'b0, 1'b0);
    checkOutput("read_ack", ack, 2'b01);
    checkOutput("read_rdata", rdata, 16'hAAAA);
    driveCycle(1'b0, 1'b0);
    checkOutput("drop_busy_after", busy, 0);

    // Single write from the data port.
    addr_v[1] = 16'h0010;
    wdata_v[1] = 16'h5555;
    we_v[1] = 1'b1;
    driveCycle(1'b0, 1'b1);
    driveCycle(1'b0, 1'b1);
    checkOutput("write_mem_we", mem_we, 1);
    checkOutput("write_mem_addr", mem_addr, 16'h0010);
    checkOutput("write_mem_wdata", mem_wdata, 16'h5555);
    driveCycle(1'b0, 1'b0);
    checkOutput("write_ack", ack, 2'b10);
    driveCycle(1'b0, 1'b0);

    // Reset asserted in the middle of an ACCESS cycle.
    addr_v[0] = 16'h0042;
    we_v[0] = 1'b1;
    wdata_v[0] = 16'hBEEF;
    driveCycle(1'b1, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("prereset_mem_en", mem_en, 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    applyStimulus(1'b0, 1'b0);
    we_v[0] = 1'b0;
    resetModel();
    driveCycle(1'b0, 1'b0);
    driveCycle(1'b0, 1'b0);
    rst_n = 1'b1;

    // Both requests held high straight after reset.
    addr_v[0] = 16'h0101;
    addr_v[1] = 16'h0202;
    we_v[1] = 1'b0;
    gnt_log.delete();
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    for (int c = 0; c < 12; c++) driveCycle(1'b1, 1'b1);
    checkOutput("tie_access_count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
`ifdef HACK_ARB_FIXED_PRIO_EN
      checkOutput($sformatf("tie_gnt%0d", k), gnt_log[k], 2'b10);
`else
      checkOutput($sformatf("tie_gnt%0d", k), gnt_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
    end
`ifdef HACK_ARB_FIXED_PRIO_EN
    checkOutput("tie_ack0_count", ack_cnt[0], 0);
    checkOutput("tie_ack1_count", ack_cnt[1], 4);
`else
    checkOutput("tie_ack0_count", ack_cnt[0], 2);
    checkOutput("tie_ack1_count", ack_cnt[1], 2);
`endif
    for (int c = 0; c < 3; c++) driveCycle(1'b0, 1'b0);

    // Random traffic: fields are held from request until ack, req may drop in ACCESS.
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checkCycle();
      if (phase == 1 && $urandom_range(0, 3) == 0) req_v[win_m] = 1'b0;
      if (phase == 2) begin
        pending[win_m] = 1'b0;
        req_v[win_m] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!pending[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pending[i] = 1'b1;
            req_v[i] = 1'b1;
            addr_v[i] = {8'($urandom), 4'h0, 4'($urandom)};
            wdata_v[i] = 16'($urandom);
            we_v[i] = 1'($urandom);
          end else begin
            req_v[i] = 1'b0;
          end
        end
      end
      advanceModel();
    end
    for (int c = 0; c < 4; c++) driveCycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_mem_arbiter.md
HACK_MEM_ARBITER -- requirements
Module: hack_mem_arbiter

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 16, setting the data and address width.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: access requests; req0 is instruction fetch, req1 is data.
REQ-005 The block SHALL have ports addr0 and addr1, input, DATA_W bits each: request addresses.
REQ-006 The block SHALL have ports wdata0 and wdata1, input, DATA_W bits each: write data.
REQ-007 The block SHALL have ports we0 and we1, input, 1 bit each: write enable, 1 for write and 0 for read.
REQ-008 The block SHALL have a port gnt, output, 2 bits: one-hot grant.
REQ-009 The block SHALL have a port ack, output, 2 bits: one-cycle completion pulse per requester.
REQ-010 The block SHALL have a port rdata, output, DATA_W bits: read data, valid while ack is nonzero.
REQ-011 The block SHALL have ports mem_en (output, 1 bit), mem_we (output, 1 bit), mem_addr (output, DATA_W bits) and mem_wdata (output, DATA_W bits): the shared memory port.
REQ-012 The block SHALL have a port mem_rdata, input, DATA_W bits: memory read data, valid one cycle after mem_en.
REQ-013 The block SHALL have a port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE, when req0 or req1 is high, the FSM SHALL latch the winner into sel and move to ACCESS; otherwise it SHALL stay in IDLE.
REQ-016 ACCESS SHALL last one cycle, with mem_en=1; mem_addr, mem_wdata and mem_we SHALL come from requester sel through 16-bit muxes.
REQ-017 RESP SHALL last one cycle: ack[sel]=1, rdata=mem_rdata, then return to IDLE.
REQ-018 Latency SHALL be fixed: a request sampled at edge N gives mem_en in cycle N+1 and ack in cycle N+2; sustained throughput is one access per 3 cycles.
REQ-019 gnt[sel] SHALL be high during ACCESS and RESP and zero in IDLE; at most one bit SHALL ever be set.
REQ-020 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-021 Outside RESP, ack SHALL be 2'b00 and rdata SHALL be 0.
REQ-022 Requesters SHALL hold addr, wdata and we stable from request until ack; the block SHALL NOT register them.
REQ-023 If req drops during ACCESS, the access SHALL still complete and ack SHALL still pulse.
REQ-024 req may stay high in the ack cycle to request a new access; it SHALL be re-arbitrated in the next IDLE.
REQ-025 Round-robin: register last (1 bit) SHALL be updated to sel on entering ACCESS.
REQ-026 When both requests are high, the requester not equal to last SHALL win; a single request SHALL always win.
REQ-027 A write access SHALL still pulse ack; rdata in that cycle is mem_rdata, meaningless to the requester.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously force state=IDLE, sel=0 and last=1, so req0 wins the first tie.
REQ-029 Reset SHALL force all outputs to 0 (gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy).
REQ-030 Reset mid-access SHALL abort the access with no ack; memory sees mem_en drop immediately.
REQ-031 After rst_n deasserts, arbitration SHALL start on the first rising edge.

Configuration
REQ-032 With macro HACK_ARB_FIXED_PRIO_EN defined, req1 (data) SHALL always win a tie and last SHALL be unused.
REQ-033 With HACK_ARB_FIXED_PRIO_EN undefined, the round-robin rules of REQ-025 and REQ-026 SHALL apply.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, ACCESS, RESP), the width constant and the requester index constants FETCH=0 and DATA=1.
REQ-035 The address and write-data selection SHALL instantiate the existing mux16 sub-module, with sel driving its select.

Verification
REQ-036 Reset with rst_n=0 mid-ACCESS -> all outputs 0 on the same cycle, no ack, FSM in IDLE.
REQ-037 Single read: req0=1, addr0=16'h1234, memory returns 16'hAAAA -> mem_en at N+1 with mem_addr=16'h1234, then ack=2'b01 and rdata=16'hAAAA at N+2.
REQ-038 Single write: req1=1, we1=1, addr1=16'h0010, wdata1=16'h5555 -> mem_we=1, mem_addr=16'h0010, mem_wdata=16'h5555 in ACCESS, then ack=2'b10.
REQ-039 Both requests held high after reset -> grants alternate 01,10,01,10 with an ack every 3 cycles (round-robin build).
REQ-040 Same both-high stimulus, built with HACK_ARB_FIXED_PRIO_EN -> gnt=2'b10 every access and req0 is never acked.
REQ-041 req0 dropped during ACCESS -> ack[0] still pulses next cycle, then busy=0.
